// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: pc owner and 2-entry fetch queue feeding decode; optional perf counters under FETCH_PERF_CNT_EN
module instr_fetch_unit #(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     HALT_WORD = 32'h6000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic            halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_count
`endif
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [PC_W-1:0] q_pc [2];
    logic [PC_W-1:0] q_pc_nxt [2];
    logic [31:0]     q_instr [2];
    logic [31:0]     q_instr_nxt [2];
    logic [1:0]      count, count_nxt;
    logic            pop, fetch, is_halt, wr_sel;
    assign imem_addr = pc;
    assign out_valid = (count != 2'd0) & ~redirect_valid;
    assign out_instr = q_instr[0];
    assign out_pc    = q_pc[0];
    assign halted    = state == HALTED;
    assign pop       = out_valid & out_ready;
    assign is_halt   = imem_data == HALT_WORD;
    assign fetch     = (state == RUN) & ~redirect_valid & ((count != 2'd2) | pop);
    assign wr_sel    = pop ? (count == 2'd2) : (count == 2'd1);
    // next state and pc: redirect wins, a fetched halt word freezes pc and stops fetching
    always_comb begin
        state_nxt = redirect_valid ? RUN : (fetch & is_halt) ? HALTED : state;
        pc_nxt    = redirect_valid ? redirect_pc : (fetch & ~is_halt) ? pc + 1'b1 : pc;
    end
    // shift queue: entry 0 is the head; pop shifts down, push lands in the first free slot after the pop
    always_comb begin
        q_pc_nxt    = q_pc;
        q_instr_nxt = q_instr;
        count_nxt   = count;
        if (redirect_valid) begin
            count_nxt = 2'd0;
        end else begin
            if (pop) begin
                q_pc_nxt[0]    = q_pc[1];
                q_instr_nxt[0] = q_instr[1];
            end
            if (fetch) begin
                q_pc_nxt[wr_sel]    = pc;
                q_instr_nxt[wr_sel] = imem_data;
            end
            count_nxt = count - {1'b0, pop} + {1'b0, fetch};
        end
    end
    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_nxt;
    end
    // pc and queue storage, cleared so the head outputs read zero out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            count   <= 2'd0;
            q_pc    <= '{default: '0};
            q_instr <= '{default: '0};
        end else begin
            pc      <= pc_nxt;
            count   <= count_nxt;
            q_pc    <= q_pc_nxt;
            q_instr <= q_instr_nxt;
        end
    end
`ifdef FETCH_PERF_CNT_EN
    // saturating counters of pushes and of run cycles that could not fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (fetch && fetch_count != '1) fetch_count <= fetch_count + 1'b1;
            if (state == RUN && !redirect_valid && !fetch && stall_count != '1) stall_count <= stall_count + 1'b1;
        end
    end
`endif
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction memory's combinational read port.
- Owns the program counter and drives the memory read address; the returned word comes back in the same cycle.
- Buffers fetched words in a 2-entry queue and hands {pc, instr} to decode over a valid/ready handshake.
- Handles redirects (branch/jump) and stops fetching when it fetches the halt word.

Parameters:
- PC_W, 32, program counter width; addresses are word indices, incremented by 1.
- RESET_PC, 0, PC value loaded on reset.
- HALT_WORD, 32'h6000_0000, instruction encoding that stops fetch.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low.
- imem_addr  output  PC_W  read address to instruction memory; equals current pc; memory indexes low 16 bits.
- imem_data  input  32  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  single-cycle request to load a new PC and flush.
- redirect_pc  input  PC_W  target PC for the redirect.
- out_valid  output  1  queue head is valid for decode.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  32  instruction at the queue head.
- out_pc  output  PC_W  PC of the instruction at the queue head.
- halted  output  1  fetch is stopped in the HALTED state.

Behaviour:
- Reset (rst low, asynchronous) forces:
  - pc=RESET_PC, queue count=0, state=RUN.
  - out_valid=0, out_instr=0, out_pc=0, halted=0.
- imem_addr = pc, combinationally, at all times.
- States:
  - RUN: fetch enabled.
  - HALTED: no fetch, pc frozen, halted=1.
- Queue: 2 entries of {pc, instr}, FIFO order, count in 0..2.
- Handshake:
  - pop = out_valid & out_ready.
  - out_valid = (count!=0) & ~redirect_valid.
  - out_instr/out_pc come from registered head storage and are stable while out_valid=1 and out_ready=0.
- Fetch condition: state==RUN & ~redirect_valid & (count<2 | pop). On fetch:
  - push {pc, imem_data}.
  - If imem_data != HALT_WORD: pc <= pc+1, stay in RUN.
  - If imem_data == HALT_WORD: the halt word is still pushed, pc holds, state -> HALTED.
- Latency: a word at pc reaches out_valid in the cycle after the fetch, then stays presented until popped.
- Throughput: 1 instruction/cycle with out_ready held high.
- Full queue (count==2):
  - Without pop: no fetch and pc holds; this counts as a stall.
  - With pop: pop and push in the same cycle, count stays 2.
- Empty queue with a pop request: impossible, since out_valid=0.
- Redirect (highest priority):
  - Queue cleared (count=0), pc <= redirect_pc, state -> RUN (also exits HALTED), halted=0 the next cycle.
  - No push and no pop take effect that cycle.
  - First redirected word becomes valid 2 cycles after redirect_valid.
- Wrap-around: pc+1 wraps modulo 2^PC_W; memory aliasing at 64K words is the memory's concern.
- Reset mid-operation: immediate asynchronous clear regardless of handshake state; pending queue contents are discarded.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_count[31:0] and stall_count[31:0], both reset to 0, both saturating at 32'hFFFF_FFFF.
  - fetch_count increments on every push.
  - stall_count increments on every cycle with state==RUN & ~redirect_valid & no fetch.
- Undefined: the ports and the logic are absent; all other behaviour is identical.

Test Plan:
- Reset, memory words 0..3 = distinct values, out_ready=1 -> out_pc 0,1,2,3 on consecutive cycles starting 1 cycle after reset release; out_instr matches memory.
- out_ready=0 for 5 cycles after reset -> count saturates at 2; pc stops at 2; out_pc stays 0; stall_count=3 (with FETCH_PERF_CNT_EN); raising out_ready resumes in order 0,1,2.
- Word 4 = 32'h6000_0000 -> halt word delivered with out_pc=4; halted=1 next cycle; imem_addr stays 4; no further out_valid.
- While HALTED: redirect_valid=1, redirect_pc=1 -> halted=0; queue empty; out_pc=1 valid 2 cycles later.
- Queue full with out_ready=0, then redirect_pc=13 -> out_valid drops in the redirect cycle; old entries never emerge; next out_pc=13.
- Set pc near 2^PC_W-1 via redirect -> out_pc sequence FFFF_FFFF then 0000_0000.
- Assert rst low mid-stream with out_valid=1 -> out_valid, out_instr and out_pc go to 0 immediately, before the next clock edge.
